// File: rtl/arm_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arm_seq_ctrl_pkg
// Brief    : Shared FSM encodings, ALU phase constants and opcode constants
//            for the ARM-style instruction sequencer.
// Revision : 1.0  initial release
// ============================================================================
package arm_seq_ctrl_pkg;

    // Sequencer FSM state encodings
    localparam logic [2:0] C_ST_IDLE  = 3'd0;
    localparam logic [2:0] C_ST_FETCH = 3'd1;
    localparam logic [2:0] C_ST_EXEC1 = 3'd2;
    localparam logic [2:0] C_ST_EXEC2 = 3'd3;
    localparam logic [2:0] C_ST_HALT  = 3'd4;
    localparam logic [2:0] C_ST_FAULT = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = C_ST_IDLE,
        S_FETCH = C_ST_FETCH,
        S_EXEC1 = C_ST_EXEC1,
        S_EXEC2 = C_ST_EXEC2,
        S_HALT  = C_ST_HALT,
        S_FAULT = C_ST_FAULT
    } state_t;

    // One-hot phase vector consumed by the ALU
    localparam logic [2:0] PH_NONE  = 3'b000;
    localparam logic [2:0] PH_FETCH = 3'b001;
    localparam logic [2:0] PH_EXEC1 = 3'b010;
    localparam logic [2:0] PH_EXEC2 = 3'b100;

    // Instruction decode constants
    localparam logic [3:0]  OP_LDR    = 4'b1110;
    localparam logic [15:0] HALT_INST = 16'h0000;

    // Map an FSM state to the phase vector the ALU sees
    function automatic logic [2:0] phase_of(input state_t s);
        case (s)
            S_FETCH: phase_of = PH_FETCH;
            S_EXEC1: phase_of = PH_EXEC1;
            S_EXEC2: phase_of = PH_EXEC2;
            default: phase_of = PH_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/arm_seq_ctrl_fetch_timer.sv
`default_nettype none
// ============================================================================
// Module   : arm_fetch_timer
// Brief    : Loadable down-counter that flags a fetch timeout once TIMEOUT
//            consecutive waiting cycles have elapsed. TIMEOUT=0 disables it.
// Revision : 1.0  initial release
// ============================================================================
module arm_fetch_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);

    generate
        if (TIMEOUT == 0) begin : g_disabled
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst_n, load, en};
            assign expire   = 1'b0;
        end else begin : g_enabled
            localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
            logic [CW-1:0] r_count;

            // Preload while idle so the first waiting cycle sees TIMEOUT-1;
            // the cycle that finds zero is the TIMEOUT-th waiting cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_count <= '0;
                end else if (load) begin
                    r_count <= CW'(TIMEOUT - 1);
                end else if (en && (r_count != '0)) begin
                    r_count <= r_count - 1'b1;
                end
            end

            assign expire = en && (r_count == '0);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/arm_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : arm_seq_ctrl
// Brief    : Multi-cycle instruction sequencer: owns PC, instruction register
//            and the one-hot ALU phase vector; handles fetch handshake, LDR
//            load phase, halt detection and fetch-timeout fault.
// Revision : 1.0  initial release
// ============================================================================
module arm_seq_ctrl
    import arm_seq_ctrl_pkg::*;
#(
    parameter int PC_W     = 8,
    parameter int RESET_PC = 0,
    parameter int TIMEOUT  = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            go,
    input  logic            single_step,
    input  logic [15:0]     imem_data,
    input  logic            imem_valid,
    input  logic            dmem_ready,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_req,
    output logic [15:0]     inst,
    output logic [2:0]      state,
    output logic [15:0]     retired,
    output logic            busy,
    output logic            halted,
    output logic            fault
);

    state_t          r_state;
    state_t          w_next;
    logic [PC_W-1:0] r_pc;
    logic [15:0]     r_inst;
    logic [15:0]     r_retired;
    logic            r_step;
    logic            w_retire;
    logic            w_load_inst;
    logic            w_expire;
    logic            w_tmr_load;
    logic            w_tmr_en;

    // Timer counts only while FETCH is stalled; reloaded in every other state
    assign w_tmr_load = (r_state != S_FETCH);
    assign w_tmr_en   = (r_state == S_FETCH) && !imem_valid;

    arm_fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_fetch_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (w_tmr_load),
        .en     (w_tmr_en),
        .expire (w_expire)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode plus retire / instruction-load strobes
    always_comb begin
        w_next      = r_state;
        w_retire    = 1'b0;
        w_load_inst = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (go) w_next = S_FETCH;
            end
            S_FETCH: begin
                if (imem_valid) begin
                    w_load_inst = 1'b1;
                    w_next      = S_EXEC1;
                end else if (w_expire) begin
                    w_next = S_FAULT;
                end
            end
            S_EXEC1: begin
                if (r_inst == HALT_INST) begin
                    w_next = S_HALT;
                end else if (r_inst[15:12] == OP_LDR) begin
                    w_next = S_EXEC2;
                end else begin
                    w_retire = 1'b1;
                    w_next   = r_step ? S_IDLE : S_FETCH;
                end
            end
            S_EXEC2: begin
                if (dmem_ready) begin
                    w_retire = 1'b1;
                    w_next   = r_step ? S_IDLE : S_FETCH;
                end
            end
            S_HALT, S_FAULT: begin
                w_next = r_state;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // PC, instruction register, retire counter and step flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= PC_W'(RESET_PC);
            r_inst    <= '0;
            r_retired <= '0;
            r_step    <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && go) r_step <= single_step;
            if (w_load_inst) r_inst <= imem_data;
            if (w_retire) begin
                r_pc      <= r_pc + 1'b1;
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    // Outputs come straight from registers or from the state register alone
    assign imem_addr = r_pc;
    assign inst      = r_inst;
    assign retired   = r_retired;
    assign state     = phase_of(r_state);
    assign imem_req  = (r_state == S_FETCH);
    assign busy      = (r_state == S_FETCH) || (r_state == S_EXEC1) ||
                       (r_state == S_EXEC2);
    assign halted    = (r_state == S_HALT);
    assign fault     = (r_state == S_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_arm_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_arm_seq_ctrl
// Brief    : Directed self-checking bench for arm_seq_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_arm_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        go;
    logic        single_step;
    logic [15:0] imem_data;
    logic        imem_valid;
    logic        dmem_ready;
    logic [7:0]  imem_addr;
    logic        imem_req;
    logic [15:0] inst;
    logic [2:0]  state;
    logic [15:0] retired;
    logic        busy;
    logic        halted;
    logic        fault;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] prog [3] = '{16'h8000, 16'h1234, 16'h0000};

    arm_seq_ctrl #(
        .PC_W     (8),
        .RESET_PC (0),
        .TIMEOUT  (15)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .go          (go),
        .single_step (single_step),
        .imem_data   (imem_data),
        .imem_valid  (imem_valid),
        .dmem_ready  (dmem_ready),
        .imem_addr   (imem_addr),
        .imem_req    (imem_req),
        .inst        (inst),
        .state       (state),
        .retired     (retired),
        .busy        (busy),
        .halted      (halted),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        go          = 1'b0;
        single_step = 1'b0;
        imem_valid  = 1'b1;
        imem_data   = 16'h8000;
        dmem_ready  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Pulse go from IDLE; returns at the first FETCH-cycle negedge
    task automatic start(input logic step, input logic [15:0] data);
        go          = 1'b1;
        single_step = step;
        imem_data   = data;
        tick();
        go          = 1'b0;
        single_step = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        go          = 1'b0;
        single_step = 1'b0;
        imem_data   = 16'h0000;
        imem_valid  = 1'b0;
        dmem_ready  = 1'b0;

        // ---- reset values ----
        #2;
        check("rst_state",   {29'd0, state}, 32'd0);
        check("rst_addr",    {24'd0, imem_addr}, 32'd0);
        check("rst_inst",    {16'd0, inst}, 32'd0);
        check("rst_retired", {16'd0, retired}, 32'd0);
        check("rst_flags",   {27'd0, imem_req, busy, halted, fault}, 32'd0);

        // ---- three-instruction program ending in HALT ----
        do_reset();
        start(1'b0, prog[0]);
        for (int i = 0; i < 3; i++) begin
            check("prog_fetch_state", {29'd0, state}, 32'd1);
            check("prog_fetch_addr",  {24'd0, imem_addr}, i);
            imem_data = prog[i];
            tick();
            check("prog_exec1_state", {29'd0, state}, 32'd2);
            check("prog_exec1_inst",  {16'd0, inst}, {16'd0, prog[i]});
            tick();
        end
        check("halt_state",   {29'd0, state}, 32'd0);
        check("halt_flag",    {31'd0, halted}, 32'd1);
        check("halt_retired", {16'd0, retired}, 32'd2);
        check("halt_addr",    {24'd0, imem_addr}, 32'd2);
        check("halt_busy",    {31'd0, busy}, 32'd0);
        go = 1'b1;
        tick(); tick();
        go = 1'b0;
        check("halt_go_ignored", {29'd0, state, halted}, 32'd1);

        // ---- LDR with three dmem_ready-low cycles ----
        do_reset();
        start(1'b0, 16'hE000);
        check("ldr_fetch", {29'd0, state}, 32'd1);
        tick();
        check("ldr_exec1", {29'd0, state}, 32'd2);
        tick();
        for (int k = 0; k < 4; k++) begin
            check("ldr_exec2_state",   {29'd0, state}, 32'd4);
            check("ldr_exec2_inst",    {16'd0, inst}, 32'hE000);
            check("ldr_exec2_retired", {16'd0, retired}, 32'd0);
            if (k == 3) begin
                dmem_ready = 1'b1;
                imem_data  = 16'h0000;
            end
            tick();
        end
        dmem_ready = 1'b0;
        check("ldr_after_state",   {29'd0, state}, 32'd1);
        check("ldr_after_retired", {16'd0, retired}, 32'd1);
        check("ldr_after_addr",    {24'd0, imem_addr}, 32'd1);

        // ---- single step ----
        do_reset();
        start(1'b1, 16'h8000);
        check("ss_fetch", {29'd0, state}, 32'd1);
        tick();
        check("ss_exec1", {29'd0, state}, 32'd2);
        tick();
        check("ss_idle_state",   {29'd0, state}, 32'd0);
        check("ss_idle_busy",    {31'd0, busy}, 32'd0);
        check("ss_idle_retired", {16'd0, retired}, 32'd1);
        tick();
        check("ss_stays_idle", {29'd0, state}, 32'd0);
        start(1'b1, 16'h1234);
        check("ss2_fetch_addr", {21'd0, imem_addr, state}, {21'd0, 8'd1, 3'd1});
        tick();
        check("ss2_exec1", {16'd0, inst}, 32'h1234);
        tick();
        check("ss2_idle", {13'd0, retired, state}, {13'd0, 16'd2, 3'd0});

        // ---- fetch timeout ----
        do_reset();
        imem_valid = 1'b0;
        start(1'b0, 16'h8000);
        for (int k = 0; k < 15; k++) begin
            check("to_fetch_state", {29'd0, state}, 32'd1);
            tick();
        end
        check("to_fault",     {31'd0, fault}, 32'd1);
        check("to_state",     {29'd0, state}, 32'd0);
        check("to_req",       {30'd0, imem_req, busy}, 32'd0);
        go = 1'b1;
        imem_valid = 1'b1;
        tick(); tick();
        go = 1'b0;
        check("to_go_ignored", {29'd0, state, fault}, 32'd1);

        // ---- async reset during EXEC2 ----
        do_reset();
        start(1'b0, 16'hE000);
        tick();
        tick();
        check("mid_exec2", {29'd0, state}, 32'd4);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_state",   {29'd0, state}, 32'd0);
        check("mid_rst_addr",    {24'd0, imem_addr}, 32'd0);
        check("mid_rst_retired", {16'd0, retired}, 32'd0);
        check("mid_rst_busy",    {31'd0, busy}, 32'd0);
        tick();
        rst_n = 1'b1;
        start(1'b1, 16'h8000);
        check("restart_fetch", {29'd0, state}, 32'd1);
        tick(); tick();
        check("restart_done", {13'd0, retired, state}, {13'd0, 16'd1, 3'd0});

        // ---- PC wrap after 255 retirements ----
        do_reset();
        start(1'b0, 16'h8000);
        for (int c = 0; c < 2000 && retired != 16'd255; c++) tick();
        check("wrap_retired_255", {16'd0, retired}, 32'd255);
        check("wrap_pc_ff",       {24'd0, imem_addr}, 32'hFF);
        for (int c = 0; c < 20 && retired == 16'd255; c++) tick();
        check("wrap_retired_256", {16'd0, retired}, 32'd256);
        check("wrap_pc_00",       {24'd0, imem_addr}, 32'h00);
        imem_data = 16'h0000;
        tick(); tick(); tick();
        check("wrap_halt", {31'd0, halted}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
